// File: rtl/dcache_axi_wb_pkg.sv
// rtl/dcache_axi_wb_pkg.sv - shared widths, FSM encoding and AXI constants for the dcache writeback master
package dcache_axi_wb_pkg;

    localparam int BLOCK_NUM  = 8;
    localparam int DATA_W     = 32;
    localparam int WAY_BUS_W  = BLOCK_NUM * DATA_W;
    localparam int BEAT_IDX_W = $clog2(BLOCK_NUM);

    localparam logic [31:0] LINE_OFS_MASK  = 32'(BLOCK_NUM * DATA_W / 8 - 1);
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;

    typedef enum logic [3:0] {
        DWB_IDLE = 4'b0001,
        DWB_AW   = 4'b0010,
        DWB_W    = 4'b0100,
        DWB_B    = 4'b1000
    } dwb_state_e;

    // Line-aligned base address: clear the byte offset within a cache line
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~LINE_OFS_MASK;
    endfunction

endpackage

// File: rtl/dcache_wb_buf.sv
// rtl/dcache_wb_buf.sv - latched eviction line with per-beat word select
module dcache_wb_buf
    import dcache_axi_wb_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic [WAY_BUS_W-1:0]  line_in,
    input  logic [BEAT_IDX_W-1:0] beat_idx,
    output logic [DATA_W-1:0]     word
);

    logic [BLOCK_NUM-1:0][DATA_W-1:0] line_q;

    // Capture the whole line (or a zero-extended single store word) on accept
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= line_in;
        end
    end

    assign word = line_q[beat_idx];

endmodule

// File: rtl/dcache_axi_wb.sv
// rtl/dcache_axi_wb.sv - AXI3 write-channel initiator for dcache line evictions and uncached stores
module dcache_axi_wb
    import dcache_axi_wb_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    output logic [3:0]           awid,
    output logic [31:0]          awaddr,
    output logic [3:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic [1:0]           awlock,
    output logic [3:0]           awcache,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [3:0]           wid,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [3:0]           bid,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready,
    input  logic                 wb_req_i,
    input  logic [31:0]          wb_addr_i,
    input  logic [WAY_BUS_W-1:0] wb_data_i,
    input  logic                 uc_req_i,
    input  logic [31:0]          uc_addr_i,
    input  logic [3:0]           uc_wstrb_i,
    input  logic [31:0]          uc_wdata_i,
    output logic                 wb_ack_o,
    output logic                 uc_ack_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam logic [3:0] LINE_LEN = 4'(BLOCK_NUM - 1);

    dwb_state_e            state;
    logic [BEAT_IDX_W-1:0] beat_cnt;
    logic                  accept_wb;
    logic                  accept_uc;
    logic                  load;
    logic [WAY_BUS_W-1:0]  load_data;
    logic [DATA_W-1:0]     beat_word;
    logic                  unused_bid;

    // Line evictions win over uncached stores; both are only taken while idle
    assign accept_wb = (state == DWB_IDLE) && wb_req_i;
    assign accept_uc = (state == DWB_IDLE) && uc_req_i && !wb_req_i;
    assign load      = accept_wb || accept_uc;
    assign load_data = wb_req_i ? wb_data_i : {{(WAY_BUS_W - DATA_W){1'b0}}, uc_wdata_i};

    // Acks are masked during reset since the idle state is forced then
    assign wb_ack_o = aresetn && accept_wb;
    assign uc_ack_o = aresetn && accept_uc;

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign awsize  = AXI_SIZE_WORD;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    // One-hot state bits double as the channel valids/ready
    assign awvalid = (state == DWB_AW);
    assign wvalid  = (state == DWB_W);
    assign bready  = (state == DWB_B);
    assign wlast   = wvalid && (beat_cnt == awlen[BEAT_IDX_W-1:0]);
    assign wdata   = beat_word;
    assign done_o  = bready && bvalid;
    assign busy_o  = (state != DWB_IDLE);

    assign unused_bid = ^bid;

    dcache_wb_buf u_buf (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (load),
        .line_in  (load_data),
        .beat_idx (beat_cnt),
        .word     (beat_word)
    );

    // Writeback sequencer: accept, address phase, data beats, response
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= DWB_IDLE;
            beat_cnt <= '0;
            awaddr   <= '0;
            awlen    <= '0;
            wstrb    <= '0;
            err_o    <= 1'b0;
        end else begin
            case (state)
                DWB_IDLE: begin
                    if (accept_wb) begin
                        awaddr <= line_base(wb_addr_i);
                        awlen  <= LINE_LEN;
                        wstrb  <= 4'hF;
                        err_o  <= 1'b0;
                        state  <= DWB_AW;
                    end else if (accept_uc) begin
                        awaddr <= uc_addr_i;
                        awlen  <= 4'd0;
                        wstrb  <= uc_wstrb_i;
                        err_o  <= 1'b0;
                        state  <= DWB_AW;
                    end
                end
                DWB_AW: begin
                    if (awready) begin
                        beat_cnt <= '0;
                        state    <= DWB_W;
                    end
                end
                DWB_W: begin
                    if (wready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (wlast) begin
                            state <= DWB_B;
                        end
                    end
                end
                DWB_B: begin
                    if (bvalid) begin
                        if (bresp != 2'b00) begin
                            err_o <= 1'b1;
                        end
                        state <= DWB_IDLE;
                    end
                end
                default: state <= DWB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_wb.sv
// tb/tb_dcache_axi_wb.sv - self-checking bench for the dcache AXI writeback master
module tb_dcache_axi_wb;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [3:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [1:0]   awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready = 1'b1;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready = 1'b1;
    logic [3:0]   bid = 4'd0;
    logic [1:0]   bresp = 2'b00;
    logic         bvalid = 1'b0;
    logic         bready;
    logic         wb_req_i = 1'b0;
    logic [31:0]  wb_addr_i = '0;
    logic [255:0] wb_data_i = '0;
    logic         uc_req_i = 1'b0;
    logic [31:0]  uc_addr_i = '0;
    logic [3:0]   uc_wstrb_i = '0;
    logic [31:0]  uc_wdata_i = '0;
    logic         wb_ack_o;
    logic         uc_ack_o;
    logic         done_o;
    logic         busy_o;
    logic         err_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // slave configuration
    int         aw_delay = 0;
    logic       w_toggle = 1'b0;
    logic [1:0] resp_cfg = 2'b00;

    // observation log
    int          wb_ack_cyc = 0;
    int          uc_ack_cyc = 0;
    int          aw_cyc = 0;
    int          done_cyc = 0;
    logic [31:0] aw_addr_log = '0;
    logic [3:0]  aw_len_log = '0;
    logic [31:0] beat_log[$];
    logic        last_log[$];
    logic [3:0]  strb_log[$];
    int          beat_cyc[$];

    // transaction-level reference model
    logic        m_busy = 1'b0;
    int          m_phase = 0;
    logic [31:0] m_addr = '0;
    logic [3:0]  m_len = '0;
    logic [3:0]  m_strb = '0;
    logic [31:0] m_words[8];
    int          m_beat = 0;
    logic        m_err = 1'b0;
    logic        b_pend = 1'b0;
    int          aw_wait = 0;

    dcache_axi_wb dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .awid       (awid),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .awsize     (awsize),
        .awburst    (awburst),
        .awlock     (awlock),
        .awcache    (awcache),
        .awprot     (awprot),
        .awvalid    (awvalid),
        .awready    (awready),
        .wid        (wid),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .wvalid     (wvalid),
        .wready     (wready),
        .bid        (bid),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .wb_req_i   (wb_req_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .uc_req_i   (uc_req_i),
        .uc_addr_i  (uc_addr_i),
        .uc_wstrb_i (uc_wstrb_i),
        .uc_wdata_i (uc_wdata_i),
        .wb_ack_o   (wb_ack_o),
        .uc_ack_o   (uc_ack_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model + slave: compare at negedge, advance the model, drive slave inputs after the next posedge
    always begin
        logic live;
        logic exp_aw;
        logic exp_w;
        @(negedge aclk);
        live   = aresetn && m_busy;
        exp_aw = live && (m_phase == 1);
        exp_w  = live && (m_phase == 2);
        chk("wb_ack_o", wb_ack_o, aresetn && !m_busy && wb_req_i);
        chk("uc_ack_o", uc_ack_o, aresetn && !m_busy && uc_req_i && !wb_req_i);
        chk("busy_o", busy_o, live);
        chk("awvalid", awvalid, exp_aw);
        chk("wvalid", wvalid, exp_w);
        chk("bready", bready, live && (m_phase == 3));
        chk("done_o", done_o, live && (m_phase == 3) && bvalid);
        chk("err_o", err_o, aresetn && m_err);
        if (exp_aw) begin
            chk("awaddr", awaddr, m_addr);
            chk("awlen", awlen, m_len);
            chk("awsize", awsize, 3'b010);
            chk("awburst", awburst, 2'b01);
            chk("awid", awid, 4'd1);
            chk("aw_other", {awlock, awcache, awprot}, 9'd0);
        end
        if (exp_w) begin
            chk("wdata", wdata, m_words[m_beat]);
            chk("wstrb", wstrb, m_strb);
            chk("wlast", wlast, m_beat == int'(m_len));
            chk("wid", wid, 4'd1);
        end

        if (aresetn) begin
            if (wb_ack_o) wb_ack_cyc = cyc;
            if (uc_ack_o) uc_ack_cyc = cyc;
            if (awvalid && awready) begin
                aw_cyc      = cyc;
                aw_addr_log = awaddr;
                aw_len_log  = awlen;
            end
            if (wvalid && wready) begin
                beat_log.push_back(wdata);
                last_log.push_back(wlast);
                strb_log.push_back(wstrb);
                beat_cyc.push_back(cyc);
            end
            if (done_o) done_cyc = cyc;
        end

        if (!aresetn) begin
            m_busy  = 1'b0;
            m_phase = 0;
            m_err   = 1'b0;
            b_pend  = 1'b0;
            aw_wait = 0;
        end else begin
            if (!m_busy) begin
                if (wb_req_i) begin
                    m_addr = wb_addr_i & 32'hFFFF_FFE0;
                    m_len  = 4'd7;
                    m_strb = 4'hF;
                    for (int i = 0; i < 8; i++) m_words[i] = wb_data_i[32*i +: 32];
                    m_busy = 1'b1; m_phase = 1; m_err = 1'b0;
                end else if (uc_req_i) begin
                    m_addr     = uc_addr_i;
                    m_len      = 4'd0;
                    m_strb     = uc_wstrb_i;
                    m_words[0] = uc_wdata_i;
                    m_busy = 1'b1; m_phase = 1; m_err = 1'b0;
                end
            end else if (m_phase == 1) begin
                if (awready) begin m_phase = 2; m_beat = 0; end
            end else if (m_phase == 2) begin
                if (wready) begin
                    if (m_beat == int'(m_len)) m_phase = 3;
                    m_beat++;
                end
            end else if (m_phase == 3) begin
                if (bvalid) begin
                    if (bresp != 2'b00) m_err = 1'b1;
                    m_busy = 1'b0; m_phase = 0;
                end
            end
            if (awvalid && !awready) aw_wait++;
            else if (awvalid && awready) aw_wait = 0;
            if (wvalid && wready && wlast) b_pend = 1'b1;
            else if (bvalid && bready) b_pend = 1'b0;
        end

        @(posedge aclk);
        #1;
        awready = (aw_wait >= aw_delay);
        wready  = w_toggle ? !wready : 1'b1;
        bvalid  = b_pend;
        bresp   = b_pend ? resp_cfg : 2'b00;
    end

    task automatic reset_checks(input string tag);
        chk({tag, " rst awvalid"}, awvalid, 0);
        chk({tag, " rst wvalid"}, wvalid, 0);
        chk({tag, " rst bready"}, bready, 0);
        chk({tag, " rst wlast"}, wlast, 0);
        chk({tag, " rst done"}, done_o, 0);
        chk({tag, " rst acks"}, {wb_ack_o, uc_ack_o}, 0);
        chk({tag, " rst busy"}, busy_o, 0);
        chk({tag, " rst err"}, err_o, 0);
        chk({tag, " rst awaddr"}, awaddr, 0);
        chk({tag, " rst wdata"}, wdata, 0);
        chk({tag, " rst awlen_wstrb"}, {awlen, wstrb}, 0);
    endtask

    task automatic line_req(input logic [31:0] a, input logic [255:0] d);
        int n = 0;
        wb_addr_i = a; wb_data_i = d; wb_req_i = 1'b1;
        do begin @(negedge aclk); n++; end while (!wb_ack_o && n < 50);
        chk("wb_ack within bound", wb_ack_o, 1);
        @(posedge aclk); #1;
        wb_req_i = 1'b0;
    endtask

    task automatic uc_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        uc_addr_i = a; uc_wstrb_i = s; uc_wdata_i = d; uc_req_i = 1'b1;
        do begin @(negedge aclk); n++; end while (!uc_ack_o && n < 50);
        chk("uc_ack within bound", uc_ack_o, 1);
        @(posedge aclk); #1;
        uc_req_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin @(negedge aclk); n++; end while (!done_o && n < 200);
        chk({name, " done within bound"}, done_o, 1);
        @(posedge aclk); #1;
    endtask

    initial begin
        logic [255:0] line;
        int s;
        int n;
        int t_done;

        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        reset_checks("por");
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // line write, always-ready slave
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h11 * (i + 1);
        s = beat_log.size();
        line_req(32'h8000_1234, line);
        wait_done("line");
        chk("line awaddr", aw_addr_log, 32'h8000_1220);
        chk("line awlen", aw_len_log, 4'd7);
        chk("line beat count", beat_log.size() - s, 8);
        if (beat_log.size() >= s + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("line wdata", beat_log[s+i], 32'h11 * (i + 1));
                chk("line wlast", last_log[s+i], i == 7);
            end
            chk("line first beat cycle", beat_cyc[s] - wb_ack_cyc, 2);
            chk("line last beat cycle", beat_cyc[s+7] - wb_ack_cyc, 9);
        end
        chk("line aw cycle", aw_cyc - wb_ack_cyc, 1);
        chk("line done cycle", done_cyc - wb_ack_cyc, 10);

        // uncached store
        s = beat_log.size();
        uc_req(32'hBFAF_F000, 4'b0011, 32'hDEAD_BEEF);
        wait_done("uc");
        chk("uc awaddr", aw_addr_log, 32'hBFAF_F000);
        chk("uc awlen", aw_len_log, 4'd0);
        chk("uc beat count", beat_log.size() - s, 1);
        if (beat_log.size() >= s + 1) begin
            chk("uc wdata", beat_log[s], 32'hDEAD_BEEF);
            chk("uc wlast", last_log[s], 1);
            chk("uc wstrb", strb_log[s], 4'b0011);
        end

        // backpressure: awready held off 3 cycles, wready toggling
        aw_delay = 3;
        w_toggle = 1'b1;
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h1000_0000 + i;
        s = beat_log.size();
        line_req(32'h0000_4040, line);
        wait_done("bp");
        aw_delay = 0;
        w_toggle = 1'b0;
        chk("bp aw handshake cycle", aw_cyc - wb_ack_cyc, 4);
        chk("bp awaddr", aw_addr_log, 32'h0000_4040);
        chk("bp beat count", beat_log.size() - s, 8);
        if (beat_log.size() >= s + 8)
            for (int i = 0; i < 8; i++) chk("bp wdata order", beat_log[s+i], 32'h1000_0000 + i);
        @(posedge aclk); #1;

        // simultaneous requests: line first, store accepted the cycle after done_o
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'hC0DE_0000 + i;
        wb_addr_i = 32'h2000_0010; wb_data_i = line; wb_req_i = 1'b1;
        uc_addr_i = 32'h3000_0004; uc_wstrb_i = 4'b1100; uc_wdata_i = 32'h5555_AAAA; uc_req_i = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!wb_ack_o && n < 50);
        chk("sim wb_ack first", wb_ack_o, 1);
        chk("sim uc_ack held off", uc_ack_o, 0);
        @(posedge aclk); #1;
        wb_req_i = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!uc_ack_o && n < 50);
        chk("sim uc_ack seen", uc_ack_o, 1);
        t_done = done_cyc;
        chk("sim uc_ack after done", cyc - t_done, 1);
        @(posedge aclk); #1;
        uc_req_i = 1'b0;
        wait_done("sim uc");
        chk("sim uc awaddr", aw_addr_log, 32'h3000_0004);

        // error response, sticky until the next accept
        resp_cfg = 2'b10;
        line_req(32'h0000_1000, line);
        wait_done("err");
        resp_cfg = 2'b00;
        repeat (3) @(posedge aclk);
        #1;
        chk("err sticky", err_o, 1);
        chk("err idle busy", busy_o, 0);
        line_req(32'h0000_2000, line);
        chk("err cleared on accept", err_o, 0);
        wait_done("err next");
        chk("err after okay", err_o, 0);

        // reset mid-burst, then a fresh request
        s = beat_log.size();
        line_req(32'h0000_8000, line);
        n = 0;
        do begin @(negedge aclk); n++; end while (beat_log.size() - s < 3 && n < 50);
        chk("mid three beats", beat_log.size() - s >= 3, 1);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        reset_checks("mid");
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'hF00D_0000 + i;
        s = beat_log.size();
        line_req(32'h0000_9004, line);
        wait_done("post reset");
        chk("post reset awaddr", aw_addr_log, 32'h0000_9000);
        chk("post reset beat count", beat_log.size() - s, 8);
        if (beat_log.size() >= s + 8)
            chk("post reset last beat", beat_log[s+7], 32'hF00D_0007);

        repeat (2) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

endmodule
